// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer, stall and flush.
// Define PIPE_NOP_INJECT_EN to load NOP_INSTR into the instruction field on reset/flush and while empty.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 96,
  parameter logic [DATA_W-1:0]  RESET_VAL = {DATA_W{1'b0}},
  parameter int                 INSTR_LSB = 64,
  parameter logic [31:0]        NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

`ifdef PIPE_NOP_INJECT_EN
  localparam logic NOP_EN = 1'b1;
`else
  localparam logic NOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   main_r;
  logic [DATA_W-1:0]   skid_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                in_fire_s;
  logic                out_fire_s;
  logic [DATA_W-1:0]   out_data_s;

  function automatic logic [DATA_W-1:0] reset_word();
    logic [DATA_W-1:0] w;
    w = RESET_VAL;
    if (NOP_EN) begin
      w[INSTR_LSB +: 32] = NOP_INSTR;
    end
    return w;
  endfunction

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready & ~stall;

  // Occupancy FSM; handshake flags are updated alongside the state so they stay registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= EMPTY;
      main_r      <= reset_word();
      skid_r      <= reset_word();
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      // Flush wins over stall and both fires; any presented input is dropped.
      state_r     <= EMPTY;
      main_r      <= reset_word();
      skid_r      <= reset_word();
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            main_r      <= in_data;
            state_r     <= ONE;
            out_valid_r <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_r <= in_data;
          end else if (in_fire_s) begin
            skid_r     <= in_data;
            state_r    <= FULL;
            in_ready_r <= 1'b0;
          end else if (out_fire_s) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire_s) begin
            main_r     <= skid_r;
            state_r    <= ONE;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          main_r      <= reset_word();
          skid_r      <= reset_word();
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Output bus: raw main register, or a bubble in the instruction field while empty.
  always_comb begin
    out_data_s = main_r;
    if (NOP_EN && !out_valid_r) begin
      out_data_s[INSTR_LSB +: 32] = NOP_INSTR;
    end else begin
      out_data_s = main_r;
    end
  end

  assign out_data  = out_data_s;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign occupancy = state_r;

endmodule
